fifo_pkt_reader: RTL and testbench



---
 rtl/fifo_pkt_reader_if.sv | 29 ++
 rtl/fifo_pkt_reader.sv | 159 +++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkt_reader_if.sv
// Bus bundle between the packet reader, the FIFO read port and the stream consumer.
// master = packet reader, slave = FIFO + consumer side.
interface fifo_pkt_reader_if #(
  parameter int ADDR  = 4,
  parameter int WIDTH = 32
);
  logic             fifo_empty;
  logic [ADDR:0]    data_avail;
  logic [WIDTH-1:0] read_data;
  logic             read_en;
  logic             snap_rdaddr;
  logic             roll_rdaddr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             pkt_ack;
  logic             pkt_nack;

  modport master (
    input  fifo_empty, data_avail, read_data, out_ready, pkt_ack, pkt_nack,
    output read_en, snap_rdaddr, roll_rdaddr, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, data_avail, read_data, out_ready, pkt_ack, pkt_nack,
    input  read_en, snap_rdaddr, roll_rdaddr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Packet read engine on the FIFO read side: reads a length-prefixed packet,
// streams it out through a 2-entry buffer, and replays it on nack by rolling
// the FIFO read pointer back to the snapshot taken at the header read.
module fifo_pkt_reader #(
  parameter int ADDR  = 4,
  parameter int WIDTH = 32
) (
  input  logic              rdclk,
  input  logic              rst_rdclk,
  fifo_pkt_reader_if.master bus,
  output logic              busy,
  output logic [7:0]        replay_count
);

  typedef enum logic [2:0] {IDLE, HDR, PAY, DRAIN, WAIT_ACK, RECOVER} state_t;

  state_t                state_q, state_d;
  logic [ADDR-1:0]       issue_cnt_q, issue_cnt_d;  // payload reads still to issue
  logic                  rd_en_q, rd_en_d;          // a read is returning this cycle
  logic                  rd_hdr_q, rd_hdr_d;        // returning word is the header
  logic                  rd_last_q, rd_last_d;      // returning word is the last payload
  logic                  rec_q, rec_d;              // second RECOVER cycle
  logic [7:0]            replay_q, replay_d;

  logic [1:0][WIDTH-1:0] buf_data_q, buf_data_d;
  logic [1:0]            buf_last_q, buf_last_d;
  logic                  buf_wr_q, buf_wr_d;
  logic                  buf_rd_q, buf_rd_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;

  logic [ADDR-1:0]       hdr_len;
  logic                  push, pop, push_last, gate_ok;
  logic                  rd_req, snap_req, roll_req;
  logic [2:0]            occ_next;

  assign hdr_len   = bus.read_data[ADDR-1:0];
  assign pop       = bus.out_valid & bus.out_ready;
  assign push      = rd_en_q;
  assign push_last = rd_last_q | (rd_hdr_q & (hdr_len == '0));

  // A read may issue only if the FIFO holds a word not already claimed by the
  // in-flight read, and the buffer will have a free slot when it returns.
  assign occ_next = {1'b0, buf_cnt_q} + {2'b00, rd_en_q} - {2'b00, pop};
  assign gate_ok  = (bus.data_avail > {{ADDR{1'b0}}, rd_en_q}) && (occ_next < 3'd2);

  // Strobes are masked by reset so they drop the instant reset asserts.
  assign bus.read_en     = rd_req & rst_rdclk;
  assign bus.snap_rdaddr = snap_req & rst_rdclk;
  assign bus.roll_rdaddr = roll_req;
  assign bus.out_valid   = (buf_cnt_q != 2'd0);
  assign bus.out_data    = buf_data_q[buf_rd_q];
  assign bus.out_last    = bus.out_valid & buf_last_q[buf_rd_q];
  assign busy            = (state_q != IDLE);
  assign replay_count    = replay_q;
  assign rd_en_d         = bus.read_en;

  // Next-state logic and read/snapshot/rollback strobes.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rec_d       = rec_q;
    replay_d    = replay_q;
    rd_hdr_d    = 1'b0;
    rd_last_d   = 1'b0;
    rd_req      = 1'b0;
    snap_req    = 1'b0;
    roll_req    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gate_ok) begin
          rd_req   = 1'b1;
          snap_req = 1'b1;
          rd_hdr_d = 1'b1;
          state_d  = HDR;
        end
      end
      HDR: begin
        // header word is on read_data this cycle
        issue_cnt_d = hdr_len;
        state_d     = (hdr_len == '0) ? DRAIN : PAY;
      end
      PAY: begin
        if (gate_ok && issue_cnt_q != '0) begin
          rd_req      = 1'b1;
          issue_cnt_d = issue_cnt_q - ADDR'(1);
          if (issue_cnt_q == ADDR'(1)) begin
            rd_last_d = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && bus.out_last) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.pkt_ack) begin
          state_d = IDLE;
        end else if (bus.pkt_nack) begin
          roll_req = 1'b1;
          replay_d = (replay_q != 8'hFF) ? replay_q + 8'd1 : replay_q;
          rec_d    = 1'b0;
          state_d  = RECOVER;
        end
      end
      RECOVER: begin
        rec_d = ~rec_q;
        if (rec_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // In-order 2-entry output buffer; returning read data lands here.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;
    buf_cnt_d  = buf_cnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      buf_data_d[buf_wr_q] = bus.read_data;
      buf_last_d[buf_wr_q] = push_last;
      buf_wr_d             = ~buf_wr_q;
    end
    if (pop) buf_rd_d = ~buf_rd_q;
  end

  // State and datapath registers; reset discards any buffered data.
  always_ff @(posedge rdclk or negedge rst_rdclk) begin
    if (!rst_rdclk) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      rd_hdr_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rec_q       <= 1'b0;
      replay_q    <= 8'd0;
      buf_data_q  <= '0;
      buf_last_q  <= '0;
      buf_wr_q    <= 1'b0;
      buf_rd_q    <= 1'b0;
      buf_cnt_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_hdr_q    <= rd_hdr_d;
      rd_last_q   <= rd_last_d;
      rec_q       <= rec_d;
      replay_q    <= replay_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      buf_wr_q    <= buf_wr_d;
      buf_rd_q    <= buf_rd_d;
      buf_cnt_q   <= buf_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Scoreboard bench for fifo_pkt_reader: a behavioural FIFO with snapshot and
// rollback feeds random packets; expected beats are queued when a packet is
// issued (and again on each nack) and a negedge monitor checks the stream.
module tb_fifo_pkt_reader;
  localparam int ADDR  = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1 << ADDR;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic       rdclk = 1'b0;
  logic       rst_rdclk = 1'b0;
  logic       busy;
  logic [7:0] replay_count;

  fifo_pkt_reader_if #(.ADDR(ADDR), .WIDTH(WIDTH)) bus ();

  fifo_pkt_reader #(.ADDR(ADDR), .WIDTH(WIDTH)) dut (
    .rdclk       (rdclk),
    .rst_rdclk   (rst_rdclk),
    .bus         (bus),
    .busy        (busy),
    .replay_count(replay_count)
  );

  always #5 rdclk = ~rdclk;

  beat_t            expq[$];
  beat_t            cur_pkt[$];
  logic [WIDTH-1:0] wq[$];
  int               vectors = 0;
  int               errors  = 0;
  int               done_cnt = 0;
  int               pop_cnt  = 0;
  int               rmode = 0;
  int               wmode = 0;
  int               exp_rc = 0;
  bit               mon_en = 1'b0;

  // behavioural FIFO: pointers carry one wrap bit
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR:0]    wp = '0, rp = '0, sp = '0, hdr_pos = '0;
  logic [ADDR:0]    occ;
  int               wcnt = 0;

  assign occ            = wp - rp;
  assign bus.fifo_empty = (wp == rp);

  // FIFO model: 1-cycle read latency, registered occupancy, snap/roll of rp.
  always @(posedge rdclk) begin
    wcnt <= wcnt + 1;
    bus.data_avail <= occ;
    if (bus.read_en) bus.read_data <= mem[rp[ADDR-1:0]];
    if (bus.snap_rdaddr) sp <= rp;
    if (bus.roll_rdaddr) rp <= sp;
    else if (bus.read_en) rp <= rp + 1'b1;
    if (wq.size() != 0 && occ < DEPTH &&
        (wmode == 0 || (wmode == 1 && wcnt % 3 == 0) ||
         (wmode == 2 && $urandom_range(0, 1) == 1))) begin
      mem[wp[ADDR-1:0]] <= wq.pop_front();
      wp <= wp + 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  endtask

  // Consumer ready: always / 1,0,0,1 pattern / random.
  initial begin
    int k;
    k = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge rdclk); #1;
      k++;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
        default: bus.out_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: stream scoreboard, stall hold, read gating and strobe rules.
  initial begin
    beat_t            e;
    logic             prev_rd, prev_stall, pl;
    logic [WIDTH-1:0] pd;
    prev_rd = 1'b0; prev_stall = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge rdclk);
      if (mon_en) begin
        if (bus.read_en) begin
          chk("read_gate", {62'd0, bus.fifo_empty, (bus.data_avail <= {{ADDR{1'b0}}, prev_rd})}, 64'd0);
          chk("roll_vs_read", bus.roll_rdaddr, 0);
        end
        if (bus.snap_rdaddr) begin
          chk("snap_with_read", bus.read_en, 1);
          chk("snap_addr", rp, hdr_pos);
        end
        if (prev_stall)
          chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, pl, pd});
        if (bus.out_valid && bus.out_ready) begin
          pop_cnt++;
          if (expq.size() == 0) begin
            chk("beat_unexpected", 1, 0);
          end else begin
            e = expq.pop_front();
            chk("beat_data", bus.out_data, e.data);
            chk("beat_last", bus.out_last, e.last);
          end
          if (bus.out_last) done_cnt++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      pd = bus.out_data;
      pl = bus.out_last;
      prev_rd = bus.read_en;
    end
  end

  task automatic issue(input int len);
    logic [WIDTH-1:0] w;
    beat_t b;
    cur_pkt.delete();
    hdr_pos = wp;
    w = $urandom;
    w[ADDR-1:0] = len[ADDR-1:0];
    wq.push_back(w);
    b.data = w; b.last = (len == 0);
    cur_pkt.push_back(b);
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      wq.push_back(w);
      b.data = w; b.last = (i == len - 1);
      cur_pkt.push_back(b);
    end
    foreach (cur_pkt[i]) expq.push_back(cur_pkt[i]);
  endtask

  task automatic wait_done();
    int base;
    base = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge rdclk);
      if (done_cnt > base) return;
    end
    errors++;
    $display("FAIL pkt_timeout: got no last beat, want one within 3000 cycles");
    summary();
  endtask

  task automatic do_ack(input bit both);
    repeat (1 + $urandom_range(0, 2)) @(posedge rdclk);
    #1;
    bus.pkt_ack = 1'b1; bus.pkt_nack = both;
    @(negedge rdclk);
    chk("ack_no_roll", bus.roll_rdaddr, 0);
    chk("ack_busy", busy, 1);
    @(posedge rdclk); #1;
    bus.pkt_ack = 1'b0; bus.pkt_nack = 1'b0;
    @(negedge rdclk);
    chk("idle_busy", busy, 0);
  endtask

  task automatic do_nack();
    repeat (1 + $urandom_range(0, 2)) @(posedge rdclk);
    #1;
    bus.pkt_nack = 1'b1;
    @(negedge rdclk);
    chk("nack_roll", bus.roll_rdaddr, 1);
    chk("nack_no_read", bus.read_en, 0);
    chk("replay_cnt_pre", replay_count, exp_rc);
    exp_rc = (exp_rc < 255) ? exp_rc + 1 : 255;
    foreach (cur_pkt[i]) expq.push_back(cur_pkt[i]);
    @(posedge rdclk); #1;
    bus.pkt_nack = 1'b0;
    @(negedge rdclk);
    chk("recover1", {bus.read_en, bus.roll_rdaddr, busy}, 3'b001);
    chk("replay_cnt", replay_count, exp_rc);
    @(negedge rdclk);
    chk("recover2", {bus.read_en, bus.roll_rdaddr, busy}, 3'b001);
    @(negedge rdclk);
    chk("resnap", {bus.read_en, bus.snap_rdaddr}, 2'b11);
  endtask

  task automatic run_pkt(input int len, input int nacks, input bit both);
    issue(len);
    for (int i = 0; i <= nacks; i++) begin
      wait_done();
      if (i < nacks) do_nack();
      else do_ack(both);
    end
  endtask

  initial begin
    int n, base;
    bus.pkt_ack = 1'b0;
    bus.pkt_nack = 1'b0;
    repeat (3) @(negedge rdclk);
    chk("rst_read_en", bus.read_en, 0);
    chk("rst_snap", bus.snap_rdaddr, 0);
    chk("rst_roll", bus.roll_rdaddr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_replay_cnt", replay_count, 0);
    rst_rdclk = 1'b1;
    mon_en = 1'b1;

    // directed: basic, replay, zero length, backpressure, trickle, ack+nack
    run_pkt(3, 0, 1'b0);
    run_pkt(3, 1, 1'b0);
    run_pkt(0, 0, 1'b0);
    rmode = 1; run_pkt(7, 0, 1'b0);
    rmode = 0; wmode = 1; run_pkt(5, 0, 1'b0);
    wmode = 0; run_pkt(2, 0, 1'b1);
    rmode = 1; run_pkt(15, 1, 1'b0);

    // randomized packets, modes and responses
    for (int p = 0; p < 30; p++) begin
      rmode = $urandom_range(0, 2);
      wmode = $urandom_range(0, 2);
      run_pkt($urandom_range(0, 15),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
              ($urandom_range(0, 9) == 0));
    end

    // replay counter saturation
    rmode = 0; wmode = 0;
    n = 255 - exp_rc + 2;
    run_pkt(0, n, 1'b0);
    chk("replay_sat", replay_count, 255);
    chk("sb_empty", expq.size(), 0);

    // reset during payload
    issue(15);
    base = pop_cnt;
    for (int i = 0; i < 2000 && pop_cnt < base + 4; i++) @(negedge rdclk);
    chk("mid_pkt_reached", (pop_cnt >= base + 4), 1);
    @(posedge rdclk); #3;
    mon_en = 1'b0;
    rst_rdclk = 1'b0;
    #1;
    chk("mrst_read_en", bus.read_en, 0);
    chk("mrst_snap", bus.snap_rdaddr, 0);
    chk("mrst_roll", bus.roll_rdaddr, 0);
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_out_last", bus.out_last, 0);
    chk("mrst_out_data", bus.out_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_replay_cnt", replay_count, 0);
    expq.delete();
    @(negedge rdclk);
    rst_rdclk = 1'b1;
    #1;
    chk("post_rst_idle", busy, 0);
    chk("post_rst_hdr_read", {bus.read_en, bus.snap_rdaddr}, 2'b11);
    summary();
  end
endmodule
